// File: rtl/contador_driver.sv
// Command-to-pin driver for a 4-bit dual-clock up/down counter: sequences CPU/CPD/PL/MR
// pulse waveforms, tracks the expected count and checks the counter's Q and TC outputs.
module contador_driver #(
    parameter int PULSE_LOW  = 2,
    parameter int PULSE_HIGH = 2,
    parameter int LOAD_W     = 2
) (
    input  logic       CLK,
    input  logic       MR,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic       done,
    output logic       CPU,
    output logic       CPD,
    output logic       PL,
    output logic       P0,
    output logic       P1,
    output logic       P2,
    output logic       P3,
    output logic       CNT_MR,
    input  logic       Q0,
    input  logic       Q1,
    input  logic       Q2,
    input  logic       Q3,
    input  logic       TCU,
    input  logic       TCD,
    output logic [3:0] q_exp,
    output logic       carry,
    output logic       err_q,
    output logic       err_tc
);

    localparam logic [1:0] OP_UP    = 2'b00;
    localparam logic [1:0] OP_DOWN  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam int MAX_LH  = (PULSE_LOW > PULSE_HIGH) ? PULSE_LOW : PULSE_HIGH;
    localparam int MAX_ALL = (MAX_LH > LOAD_W) ? MAX_LH : LOAD_W;
    localparam int CW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [CW-1:0] LOW_LAST  = CW'(PULSE_LOW - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(PULSE_HIGH - 1);
    localparam logic [CW-1:0] CTL_LAST  = CW'(LOAD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_LOADP,
        S_CLRP,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   phase;
    logic [4:0]      pulses_left;
    logic [1:0]      op_lat;
    logic [3:0]      data_lat;
    logic            armed;
    logic [3:0]      p_val;
    logic [3:0]      q_in;
    logic            accept;
    logic            low_last;
    logic            high_last;
    logic            ctl_last;

    // cmd_ready waits for the first edge after reset so a command never races MR release
    assign cmd_ready = (state == S_IDLE) && armed;
    assign accept    = cmd_valid && cmd_ready;
    assign q_in      = {Q3, Q2, Q1, Q0};
    assign low_last  = (state == S_LOW) && (phase == LOW_LAST);
    assign high_last = (state == S_HIGH) && (phase == HIGH_LAST);
    assign ctl_last  = ((state == S_LOADP) || (state == S_CLRP)) && (phase == CTL_LAST);

    // P0 carries the value MSB, P3 the LSB
    assign {P0, P1, P2, P3} = p_val;

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        CPU       = 1'b1;
        CPD       = 1'b1;
        PL        = 1'b1;
        CNT_MR    = 1'b0;
        p_val     = 4'd0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_LOAD) begin
                        state_nxt = S_LOADP;
                    end else if (cmd_op == OP_CLEAR) begin
                        state_nxt = S_CLRP;
                    end else begin
                        state_nxt = S_LOW;
                    end
                end
            end
            S_LOW: begin
                if (op_lat == OP_UP) begin
                    CPU = 1'b0;
                end else begin
                    CPD = 1'b0;
                end
                if (low_last) begin
                    state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (high_last) begin
                    state_nxt = (pulses_left == 5'd1) ? S_DONE : S_LOW;
                end
            end
            S_LOADP: begin
                PL    = 1'b0;
                p_val = data_lat;
                if (ctl_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_CLRP: begin
                CNT_MR = 1'b1;
                if (ctl_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
                if (op_lat == OP_LOAD) begin
                    p_val = data_lat;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            phase       <= '0;
            pulses_left <= 5'd0;
            q_exp       <= 4'd0;
            carry       <= 1'b0;
            err_q       <= 1'b0;
            err_tc      <= 1'b0;
            armed       <= 1'b0;
        end else begin
            armed <= 1'b1;
            carry <= 1'b0;
            if ((state_nxt != state) || (state == S_IDLE)) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
            if (accept) begin
                pulses_left <= (cmd_data == 4'd0) ? 5'd16 : {1'b0, cmd_data};
            end else if (high_last) begin
                pulses_left <= pulses_left - 5'd1;
            end
            // Count edge: the counter sees the rising clock at the LOW->HIGH boundary
            if (low_last) begin
                if (op_lat == OP_UP) begin
                    q_exp <= q_exp + 4'd1;
                    carry <= (q_exp == 4'd15);
                    if (TCU != ~(q_exp == 4'd15)) begin
                        err_tc <= 1'b1;
                    end
                end else begin
                    q_exp <= q_exp - 4'd1;
                    carry <= (q_exp == 4'd0);
                    if (TCD != ~(q_exp == 4'd0)) begin
                        err_tc <= 1'b1;
                    end
                end
            end
            if (ctl_last) begin
                q_exp <= (state == S_LOADP) ? data_lat : 4'd0;
            end
            if (high_last || ((state == S_DONE) && op_lat[1])) begin
                if (q_in != q_exp) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Command fields are data only; they are meaningful only while a command runs
    always_ff @(posedge CLK) begin
        if (accept) begin
            op_lat   <= cmd_op;
            data_lat <= cmd_data;
        end
    end

endmodule

// File: tb/tb_contador_driver.sv
// Bench for contador_driver: behavioural counter model on the pin side plus a scoreboard
// of expected per-command results.
module tb_contador_driver;

    localparam logic [1:0] OP_UP    = 2'b00;
    localparam logic [1:0] OP_DOWN  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic       clk = 1'b0;
    logic       mr  = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_data = 4'd0;
    logic       done, CPU, CPD, PL, P0, P1, P2, P3, CNT_MR;
    logic       Q0, Q1, Q2, Q3, TCU, TCD;
    logic [3:0] q_exp;
    logic       carry, err_q, err_tc;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    contador_driver #(.PULSE_LOW(2), .PULSE_HIGH(2), .LOAD_W(2)) dut (
        .CLK(clk), .MR(mr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .done(done),
        .CPU(CPU), .CPD(CPD), .PL(PL), .P0(P0), .P1(P1), .P2(P2), .P3(P3),
        .CNT_MR(CNT_MR), .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .TCU(TCU), .TCD(TCD),
        .q_exp(q_exp), .carry(carry), .err_q(err_q), .err_tc(err_tc)
    );

    // Counter model: async clear/load, counts on rising CPU/CPD; 'stuck' freezes counting
    logic [3:0] qm = 4'd0;
    logic       cpu_prev = 1'b1;
    logic       cpd_prev = 1'b1;
    bit         stuck = 1'b0;

    always @(CPU or CPD or PL or CNT_MR or P0 or P1 or P2 or P3) begin
        if (CNT_MR === 1'b1) qm = 4'd0;
        else if (PL === 1'b0) qm = {P0, P1, P2, P3};
        else if (CPU === 1'b1 && cpu_prev === 1'b0 && CPD === 1'b1) begin
            if (!stuck) qm = qm + 4'd1;
        end else if (CPD === 1'b1 && cpd_prev === 1'b0 && CPU === 1'b1) begin
            if (!stuck) qm = qm - 4'd1;
        end
        cpu_prev = CPU;
        cpd_prev = CPD;
    end

    assign {Q3, Q2, Q1, Q0} = qm;
    assign TCU = ~((qm == 4'd15) & ~CPU);
    assign TCD = ~((qm == 4'd0) & ~CPD);

    typedef struct {
        logic [3:0] q;
        int         cpu_r;
        int         cpd_r;
        int         carries;
    } exp_t;
    exp_t sb[$];

    int         obs_cpu, obs_cpd, obs_carry, obs_overlap;
    logic       obs_tcu_low, obs_tcd_low;
    logic [3:0] obs_p;
    bit         obs_done;

    // Issue one command, keep cmd_valid high with scrambled fields while it runs, observe pins
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] d);
        int n;
        logic pc, pd;
        obs_cpu = 0; obs_cpd = 0; obs_carry = 0; obs_overlap = 0;
        obs_tcu_low = 1'b0; obs_tcd_low = 1'b0; obs_p = 4'd0; obs_done = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            n_vec++; n_mis++;
            $display("FAIL accept_timeout cmd_ready=%b required 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_op = ~op; cmd_data = ~d;
        pc = 1'b1; pd = 1'b1; n = 0;
        while (!obs_done && n < 600) begin
            @(negedge clk);
            n++;
            if (CPU && !pc) obs_cpu++;
            if (CPD && !pd) obs_cpd++;
            if (!CPU && !CPD) obs_overlap++;
            if (carry) obs_carry++;
            if (!CPU && !TCU) obs_tcu_low = 1'b1;
            if (!CPD && !TCD) obs_tcd_low = 1'b1;
            if (!PL) obs_p = {P0, P1, P2, P3};
            pc = CPU; pd = CPD;
            if (done) obs_done = 1'b1;
        end
        cmd_valid = 1'b0;
        if (!obs_done) begin
            n_vec++; n_mis++;
            $display("FAIL done_timeout done=%b required 1", done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({CPU, CPD, PL, CNT_MR, P0, P1, P2, P3} !== 8'b1110_0000) begin
            n_mis++;
            $display("FAIL reset_pins got=%b required 11100000", {CPU, CPD, PL, CNT_MR, P0, P1, P2, P3});
        end
        n_vec++;
        if ({cmd_ready, done, carry, err_q, err_tc, q_exp} !== 9'd0) begin
            n_mis++;
            $display("FAIL reset_status got=%b required 0", {cmd_ready, done, carry, err_q, err_tc, q_exp});
        end
        mr = 1'b0;
        #1;
        n_vec++;
        if (cmd_ready !== 1'b0) begin
            n_mis++; $display("FAIL ready_after_release got=%b required 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_mis++; $display("FAIL ready_first_edge got=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_mr_mid_up();
        exp_t e;
        int n;
        int dones;
        sb.push_back('{q: 4'd9, cpu_r: 0, cpd_r: 0, carries: 0});
        run_cmd(OP_LOAD, 4'd9);
        e = sb.pop_front();
        n_vec++;
        if (q_exp !== e.q) begin
            n_mis++; $display("FAIL mid_load_q q_exp=%h required %h", q_exp, e.q);
        end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_UP; cmd_data = 4'd3;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (CPU !== 1'b0) begin
            n_mis++; $display("FAIL mid_cpu_low CPU=%b required 0", CPU);
        end
        mr = 1'b1;
        #1;
        n_vec++;
        if ({CPU, cmd_ready, q_exp} !== 6'b10_0000) begin
            n_mis++;
            $display("FAIL mid_abort CPU,ready,q_exp=%b required 100000", {CPU, cmd_ready, q_exp});
        end
        repeat (2) @(negedge clk);
        mr = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_vec++;
        if (dones != 0) begin
            n_mis++; $display("FAIL mid_no_done count=%0d required 0", dones);
        end
    endtask

    task automatic test_clear_up3();
        exp_t e;
        sb.push_back('{q: 4'd0, cpu_r: 0, cpd_r: 0, carries: 0});
        run_cmd(OP_CLEAR, 4'd0);
        e = sb.pop_front();
        n_vec++;
        if (q_exp !== e.q) begin
            n_mis++; $display("FAIL clear_q q_exp=%h required %h", q_exp, e.q);
        end
        sb.push_back('{q: 4'd3, cpu_r: 3, cpd_r: 0, carries: 0});
        run_cmd(OP_UP, 4'd3);
        e = sb.pop_front();
        n_vec++;
        if (q_exp !== e.q) begin
            n_mis++; $display("FAIL up3_q q_exp=%h required %h", q_exp, e.q);
        end
        n_vec++;
        if (obs_cpu != e.cpu_r || obs_cpd != e.cpd_r || obs_overlap != 0) begin
            n_mis++;
            $display("FAIL up3_edges cpu=%0d cpd=%0d overlap=%0d required %0d %0d 0",
                     obs_cpu, obs_cpd, obs_overlap, e.cpu_r, e.cpd_r);
        end
        n_vec++;
        if (obs_carry != e.carries || err_q !== 1'b0 || err_tc !== 1'b0) begin
            n_mis++;
            $display("FAIL up3_flags carry=%0d err_q=%b err_tc=%b required %0d 0 0",
                     obs_carry, err_q, err_tc, e.carries);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin
            n_mis++; $display("FAIL up3_done_once done=%b required 0", done);
        end
    endtask

    task automatic test_load_wrap();
        exp_t e;
        sb.push_back('{q: 4'hE, cpu_r: 0, cpd_r: 0, carries: 0});
        run_cmd(OP_LOAD, 4'hE);
        e = sb.pop_front();
        n_vec++;
        if (obs_p !== 4'b1110 || q_exp !== e.q) begin
            n_mis++;
            $display("FAIL load_pins P0..P3=%b q_exp=%h required 1110 %h", obs_p, q_exp, e.q);
        end
        sb.push_back('{q: 4'h0, cpu_r: 2, cpd_r: 0, carries: 1});
        run_cmd(OP_UP, 4'd2);
        e = sb.pop_front();
        n_vec++;
        if (q_exp !== e.q || obs_cpu != e.cpu_r || obs_carry != e.carries) begin
            n_mis++;
            $display("FAIL wrap_up q_exp=%h cpu=%0d carry=%0d required %h %0d %0d",
                     q_exp, obs_cpu, obs_carry, e.q, e.cpu_r, e.carries);
        end
        n_vec++;
        if (obs_tcu_low !== 1'b1 || err_tc !== 1'b0 || err_q !== 1'b0) begin
            n_mis++;
            $display("FAIL wrap_tcu tcu_low=%b err_tc=%b err_q=%b required 1 0 0",
                     obs_tcu_low, err_tc, err_q);
        end
    endtask

    task automatic test_down_wrap();
        exp_t e;
        sb.push_back('{q: 4'h0, cpu_r: 0, cpd_r: 0, carries: 0});
        run_cmd(OP_CLEAR, 4'd0);
        e = sb.pop_front();
        n_vec++;
        if (q_exp !== e.q) begin
            n_mis++; $display("FAIL down_clear q_exp=%h required %h", q_exp, e.q);
        end
        sb.push_back('{q: 4'hF, cpu_r: 0, cpd_r: 1, carries: 1});
        run_cmd(OP_DOWN, 4'd1);
        e = sb.pop_front();
        n_vec++;
        if (q_exp !== e.q || obs_cpd != e.cpd_r || obs_cpu != e.cpu_r || obs_carry != e.carries) begin
            n_mis++;
            $display("FAIL down_wrap q_exp=%h cpd=%0d cpu=%0d carry=%0d required %h %0d %0d %0d",
                     q_exp, obs_cpd, obs_cpu, obs_carry, e.q, e.cpd_r, e.cpu_r, e.carries);
        end
        n_vec++;
        if (obs_tcd_low !== 1'b1 || {Q3, Q2, Q1, Q0} !== 4'hF || err_tc !== 1'b0 || err_q !== 1'b0) begin
            n_mis++;
            $display("FAIL down_tcd tcd_low=%b Q=%b err_tc=%b err_q=%b required 1 1111 0 0",
                     obs_tcd_low, {Q3, Q2, Q1, Q0}, err_tc, err_q);
        end
    endtask

    task automatic test_up16();
        exp_t e;
        sb.push_back('{q: 4'd6, cpu_r: 0, cpd_r: 0, carries: 0});
        run_cmd(OP_LOAD, 4'd6);
        e = sb.pop_front();
        n_vec++;
        if (q_exp !== e.q) begin
            n_mis++; $display("FAIL up16_load q_exp=%h required %h", q_exp, e.q);
        end
        sb.push_back('{q: 4'd6, cpu_r: 16, cpd_r: 0, carries: 1});
        run_cmd(OP_UP, 4'd0);
        e = sb.pop_front();
        n_vec++;
        if (q_exp !== e.q || obs_cpu != e.cpu_r || obs_cpd != e.cpd_r || obs_carry != e.carries) begin
            n_mis++;
            $display("FAIL up16 q_exp=%h cpu=%0d cpd=%0d carry=%0d required %h %0d %0d %0d",
                     q_exp, obs_cpu, obs_cpd, obs_carry, e.q, e.cpu_r, e.cpd_r, e.carries);
        end
        n_vec++;
        if (err_q !== 1'b0 || err_tc !== 1'b0 || obs_overlap != 0) begin
            n_mis++;
            $display("FAIL up16_flags err_q=%b err_tc=%b overlap=%0d required 0 0 0",
                     err_q, err_tc, obs_overlap);
        end
    endtask

    task automatic test_stuck();
        exp_t e;
        sb.push_back('{q: 4'd5, cpu_r: 0, cpd_r: 0, carries: 0});
        run_cmd(OP_LOAD, 4'd5);
        e = sb.pop_front();
        n_vec++;
        if (q_exp !== e.q || err_q !== 1'b0) begin
            n_mis++; $display("FAIL stuck_load q_exp=%h err_q=%b required %h 0", q_exp, err_q, e.q);
        end
        stuck = 1'b1;
        sb.push_back('{q: 4'd6, cpu_r: 1, cpd_r: 0, carries: 0});
        run_cmd(OP_UP, 4'd1);
        stuck = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (q_exp !== e.q || err_q !== 1'b1 || err_tc !== 1'b0) begin
            n_mis++;
            $display("FAIL stuck_detect q_exp=%h err_q=%b err_tc=%b required %h 1 0",
                     q_exp, err_q, err_tc, e.q);
        end
        sb.push_back('{q: 4'd0, cpu_r: 0, cpd_r: 0, carries: 0});
        run_cmd(OP_CLEAR, 4'd0);
        e = sb.pop_front();
        n_vec++;
        if (q_exp !== e.q || err_q !== 1'b1) begin
            n_mis++; $display("FAIL stuck_sticky q_exp=%h err_q=%b required %h 1", q_exp, err_q, e.q);
        end
        @(negedge clk);
        mr = 1'b1;
        #1;
        n_vec++;
        if (err_q !== 1'b0) begin
            n_mis++; $display("FAIL stuck_mr_clear err_q=%b required 0", err_q);
        end
        @(negedge clk);
        mr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mr_mid_up();
        test_clear_up3();
        test_load_wrap();
        test_down_wrap();
        test_up16();
        test_stuck();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
